// File: rtl/cpu_instruction_fetch.sv
// Instruction fetch stage: holds the PC, reads instruction memory, presents {pc, instr} to decode.
// Latency: request registered one cycle after entering S_REQ; mem_ready at edge N -> output_valid after edge N.
// Backpressure: output_full holds the presented instruction stable; no new request is issued until transfer.
module cpu_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] output_address,
  output logic [31:0] output_instruction,
  output logic        output_valid,
  input  logic        output_full,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_mem_address;
  logic        r_mem_read;
  logic [31:0] r_out_address;
  logic [31:0] r_out_instruction;
  logic        r_out_valid;
  logic        r_fault;
  logic [31:0] r_count;

  logic        w_transfer;
  logic        w_response;
  logic        w_misaligned;
  logic [31:0] w_pc_next;

  // A transfer happens whenever a held instruction meets a non-busy decode stage.
  assign w_transfer   = r_out_valid & ~output_full;
  // Memory responses only count while a request is actually outstanding.
  assign w_response   = r_mem_read & mem_ready;
  assign w_misaligned = (branch_target[1:0] != 2'b00);
  assign w_pc_next    = r_pc + PC_STEP;

  // Fetch state machine: request, hold for decode, or halt on a misaligned redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= S_REQ;
      r_pc              <= RESET_PC;
      r_mem_address     <= 32'h0;
      r_mem_read        <= 1'b0;
      r_out_address     <= 32'h0;
      r_out_instruction <= 32'h0;
      r_out_valid       <= 1'b0;
      r_fault           <= 1'b0;
      r_count           <= 32'h0;
    end else begin
      // Transfers complete even when a redirect lands in the same cycle.
      if (w_transfer) begin
        r_count <= r_count + 32'd1;
      end

      if (r_state != S_HALT && branch_valid) begin
        // Redirect wins over everything: squash held data and drop any in-flight response.
        r_out_valid <= 1'b0;
        if (w_misaligned) begin
          r_fault    <= 1'b1;
          r_mem_read <= 1'b0;
          r_state    <= S_HALT;
        end else begin
          r_pc          <= branch_target;
          r_mem_read    <= 1'b1;
          r_mem_address <= branch_target;
          r_state       <= S_REQ;
        end
      end else begin
        case (r_state)
          S_REQ: begin
            if (w_response) begin
              r_out_instruction <= mem_rdata;
              r_out_address     <= r_pc;
              r_out_valid       <= 1'b1;
              r_mem_read        <= 1'b0;
              r_state           <= S_HOLD;
            end else begin
              r_mem_read    <= 1'b1;
              r_mem_address <= r_pc;
            end
          end
          S_HOLD: begin
            if (w_transfer) begin
              r_out_valid   <= 1'b0;
              r_pc          <= w_pc_next;
              r_mem_read    <= 1'b1;
              r_mem_address <= w_pc_next;
              r_state       <= S_REQ;
            end
          end
          S_HALT: begin
            r_mem_read  <= 1'b0;
            r_out_valid <= 1'b0;
            r_fault     <= 1'b1;
          end
          default: begin
            r_state <= S_HALT;
          end
        endcase
      end
    end
  end

  assign mem_address        = r_mem_address;
  assign mem_read           = r_mem_read;
  assign output_address     = r_out_address;
  assign output_instruction = r_out_instruction;
  assign output_valid       = r_out_valid;
  assign fetch_fault        = r_fault;
  assign fetch_count        = r_count;

endmodule

// File: tb/tb_cpu_instruction_fetch.sv
// Bench for cpu_instruction_fetch: directed stimulus with a request scoreboard and a transfer scoreboard.
// Memory model answers with address ^ 32'hA5A5_0000, optionally delaying one chosen address.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_cpu_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] output_address;
  logic [31:0] output_instruction;
  logic        output_valid;
  logic        output_full = 1'b0;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [31:0] delay_addr = 32'hFFFF_FFFF;
  int          delay_n = 0;
  int          wait_cnt = 0;

  logic [31:0] exp_req_q[$];
  logic [63:0] exp_xfer_q[$];

  cpu_instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_rdata         (mem_rdata),
    .mem_ready         (mem_ready),
    .branch_valid      (branch_valid),
    .branch_target     (branch_target),
    .output_address    (output_address),
    .output_instruction(output_instruction),
    .output_valid      (output_valid),
    .output_full       (output_full),
    .fetch_fault       (fetch_fault),
    .fetch_count       (fetch_count)
  );

  always #5 clock = ~clock;

  // Memory wait-state counter: counts cycles a request has been pending without a response.
  always @(posedge clock) begin
    if (mem_read && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign mem_ready = mem_read && !((mem_address == delay_addr) && (wait_cnt < delay_n));
  assign mem_rdata = mem_address ^ 32'hA5A5_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_xfer(input logic [31:0] a);
    exp_xfer_q.push_back({a, a ^ 32'hA5A5_0000});
  endtask

  // Monitor: pops expectations whenever a memory handshake or a decode transfer is about to occur.
  always @(negedge clock) begin
    if (started && !reset) begin
      if (mem_read && mem_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected actual=%h required=none t=%0t", mem_address, $time);
        end else begin
          check("req_addr", mem_address, exp_req_q.pop_front());
        end
      end
      if (output_valid && !output_full) begin
        if (exp_xfer_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL xfer_unexpected actual=%h required=none t=%0t", output_address, $time);
        end else begin
          logic [63:0] e;
          e = exp_xfer_q.pop_front();
          check("xfer_addr", output_address, e[63:32]);
          check("xfer_instr", output_instruction, e[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    check("req_queue_drained", exp_req_q.size(), 0);
    check("xfer_queue_drained", exp_xfer_q.size(), 0);
    reset = 1'b1;
    started = 1'b1;
    #1;
    check("rst_mem_read", {31'h0, mem_read}, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_out_valid", {31'h0, output_valid}, 32'h0);
    check("rst_out_address", output_address, 32'h0);
    check("rst_out_instr", output_instruction, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    output_full  = 1'b0;
    branch_valid = 1'b0;
    delay_addr   = 32'hFFFF_FFFF;
    delay_n      = 0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #1;

    // Test 1: zero-wait streaming, one transfer every 2 cycles.
    do_reset();
    foreach (exp_req_q[i]) ;
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
    exp_req_q.push_back(32'hC); exp_req_q.push_back(32'h10);
    push_xfer(32'h0); push_xfer(32'h4); push_xfer(32'h8); push_xfer(32'hC);
    tick(9);
    check("t1_count", fetch_count, 32'd4);
    output_full = 1'b1;
    tick(2);

    // Test 2: three wait states on address 8 while mem_read holds.
    do_reset();
    delay_addr = 32'h8;
    delay_n    = 3;
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8); exp_req_q.push_back(32'hC);
    push_xfer(32'h0); push_xfer(32'h4); push_xfer(32'h8);
    tick(5);
    for (int i = 0; i < 3; i++) begin
      check("t2_wait_mem_read", {31'h0, mem_read}, 32'h1);
      check("t2_wait_addr", mem_address, 32'h8);
      check("t2_wait_valid", {31'h0, output_valid}, 32'h0);
      tick(1);
    end
    tick(1);
    check("t2_valid", {31'h0, output_valid}, 32'h1);
    check("t2_out_addr", output_address, 32'h8);
    tick(1);
    output_full = 1'b1;
    tick(1);
    check("t2_count", fetch_count, 32'd3);

    // Test 3: decode busy for 5 cycles while address 4 is held.
    do_reset();
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
    push_xfer(32'h0); push_xfer(32'h4);
    tick(3);
    output_full = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", {31'h0, output_valid}, 32'h1);
      check("t3_stall_addr", output_address, 32'h4);
      check("t3_stall_instr", output_instruction, 32'h4 ^ 32'hA5A5_0000);
      check("t3_stall_no_req", {31'h0, mem_read}, 32'h0);
      tick(1);
    end
    output_full = 1'b0;
    tick(1);
    check("t3_next_req", {31'h0, mem_read}, 32'h1);
    check("t3_next_addr", mem_address, 32'h8);
    check("t3_count", fetch_count, 32'd2);
    output_full = 1'b1;
    tick(1);

    // Test 4: redirect squashes held address 8.
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0100;
    exp_req_q.push_back(32'h100);
    tick(1);
    branch_valid = 1'b0;
    check("t4_squash_valid", {31'h0, output_valid}, 32'h0);
    check("t4_req", {31'h0, mem_read}, 32'h1);
    check("t4_addr", mem_address, 32'h100);
    check("t4_count", fetch_count, 32'd2);
    tick(2);
    check("t4_count_after", fetch_count, 32'd2);

    // Test 5: redirect coinciding with a response, then with a transfer.
    do_reset();
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4); exp_req_q.push_back(32'h8);
    exp_req_q.push_back(32'hC); exp_req_q.push_back(32'h200); exp_req_q.push_back(32'h300);
    push_xfer(32'h0); push_xfer(32'h4); push_xfer(32'h8); push_xfer(32'h200);
    tick(7);
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0200;
    tick(1);
    branch_valid = 1'b0;
    check("t5_discard_valid", {31'h0, output_valid}, 32'h0);
    check("t5_req", {31'h0, mem_read}, 32'h1);
    check("t5_addr", mem_address, 32'h200);
    check("t5_count", fetch_count, 32'd3);
    tick(1);
    check("t5_hold_valid", {31'h0, output_valid}, 32'h1);
    check("t5_hold_addr", output_address, 32'h200);
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0300;
    tick(1);
    branch_valid = 1'b0;
    output_full  = 1'b1;
    check("t5_xfer_count", fetch_count, 32'd4);
    check("t5_redir_addr", mem_address, 32'h300);
    check("t5_redir_req", {31'h0, mem_read}, 32'h1);
    check("t5_redir_valid", {31'h0, output_valid}, 32'h0);
    tick(1);

    // Test 6: misaligned redirect halts; only reset recovers.
    do_reset();
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4);
    push_xfer(32'h0);
    tick(3);
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0102;
    tick(1);
    branch_valid = 1'b0;
    check("t6_fault", {31'h0, fetch_fault}, 32'h1);
    check("t6_mem_read", {31'h0, mem_read}, 32'h0);
    check("t6_valid", {31'h0, output_valid}, 32'h0);
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0400;
    tick(1);
    branch_valid = 1'b0;
    tick(3);
    check("t6_halt_fault", {31'h0, fetch_fault}, 32'h1);
    check("t6_halt_mem_read", {31'h0, mem_read}, 32'h0);
    check("t6_halt_valid", {31'h0, output_valid}, 32'h0);
    check("t6_halt_count", fetch_count, 32'd1);
    do_reset();
    exp_req_q.push_back(32'h0); exp_req_q.push_back(32'h4);
    push_xfer(32'h0);
    tick(3);
    check("t6_restart_count", fetch_count, 32'd1);
    check("t6_restart_req", {31'h0, mem_read}, 32'h1);
    check("t6_restart_addr", mem_address, 32'h4);
    output_full = 1'b1;
    tick(2);

    check("final_req_queue", exp_req_q.size(), 0);
    check("final_xfer_queue", exp_xfer_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
